// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrclk/sdata in the clk domain and recovers
// left/right PCM words, presenting each complete frame with a one-cycle strobe.
module i2s_rx #(
  parameter int DATA_WIDTH   = 16,
  parameter bit UNSIGNED_OUT = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  lrclk,
  input  logic                  sdata,
  output logic [DATA_WIDTH-1:0] left_chan,
  output logic [DATA_WIDTH-1:0] right_chan,
  output logic                  sample_valid,
  output logic                  frame_error
);

  localparam logic [5:0] LAST_IDX = 6'(DATA_WIDTH - 1);

  logic sclk_s0, sclk_s1, sclk_s2;
  logic lrclk_s0, lrclk_sync;
  logic sdata_s0, sdata_sync;

  logic                  primed, started, left_ok, left_short;
  logic                  lrclk_prev;
  logic [5:0]            bitcnt;
  logic [DATA_WIDTH-1:0] word, left_hold;

  logic                  rise, boundary, word_short;
  logic [5:0]            bitcnt_inc;
  logic [DATA_WIDTH-1:0] word_cap;

  function automatic logic [DATA_WIDTH-1:0] fmt(input logic [DATA_WIDTH-1:0] w);
    fmt = w;
    if (UNSIGNED_OUT) fmt[DATA_WIDTH-1] = ~w[DATA_WIDTH-1];
  endfunction

  // Word register with the bit of this rise merged in; bits past DATA_WIDTH are dropped.
  always_comb begin
    word_cap = word;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (bitcnt == 6'(DATA_WIDTH - 1 - i)) word_cap[i] = sdata_sync;
    end
  end

  assign rise       = sclk_s1 & ~sclk_s2;
  assign boundary   = primed && (lrclk_sync != lrclk_prev);
  // Total bits including this one is bitcnt+1, so the word is short below LAST_IDX.
  assign word_short = bitcnt < LAST_IDX;
  assign bitcnt_inc = (bitcnt == 6'd63) ? bitcnt : bitcnt + 6'd1;

  // NOTE: every register here is state, so only non-blocking assignments are used;
  // blocking ones would let later statements see this cycle's new values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_s0      <= 1'b0;
      sclk_s1      <= 1'b0;
      sclk_s2      <= 1'b0;
      lrclk_s0     <= 1'b0;
      lrclk_sync   <= 1'b0;
      sdata_s0     <= 1'b0;
      sdata_sync   <= 1'b0;
      primed       <= 1'b0;
      started      <= 1'b0;
      left_ok      <= 1'b0;
      left_short   <= 1'b0;
      lrclk_prev   <= 1'b0;
      bitcnt       <= '0;
      word         <= '0;
      left_hold    <= '0;
      left_chan    <= '0;
      right_chan   <= '0;
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;
    end else begin
      {sclk_s2, sclk_s1, sclk_s0} <= {sclk_s1, sclk_s0, sclk};
      {lrclk_sync, lrclk_s0}      <= {lrclk_s0, lrclk};
      {sdata_sync, sdata_s0}      <= {sdata_s0, sdata};
      sample_valid <= 1'b0;
      frame_error  <= 1'b0;

      if (rise) begin
        if (!primed) begin
          primed     <= 1'b1;
          lrclk_prev <= lrclk_sync;
        end else if (boundary) begin
          word       <= '0;
          bitcnt     <= '0;
          lrclk_prev <= lrclk_sync;
          started    <= 1'b1;
          if (started) begin
            if (!lrclk_prev) begin
              left_hold  <= word_cap;
              left_short <= word_short;
              left_ok    <= 1'b1;
            end else if (left_ok) begin
              left_chan    <= fmt(left_hold);
              right_chan   <= fmt(word_cap);
              sample_valid <= 1'b1;
              frame_error  <= left_short | word_short;
              left_ok      <= 1'b0;
            end
          end
        end else begin
          word   <= word_cap;
          bitcnt <= bitcnt_inc;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx.sv
// Bench for i2s_rx: plays an I2S stream word by word and compares each strobe
// against frames predicted from the word list (signed and offset-binary instances).
module tb_i2s_rx;
  localparam int DW = 16;

  typedef struct {
    bit          ch;
    int          len;
    logic [63:0] val;
    int          half;
    int          rst_at;
  } word_t;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic          e;
  } frame_t;

  logic clk = 1'b0;
  logic reset, sclk, lrclk, sdata;
  logic [DW-1:0] left_chan, right_chan, left_u, right_u;
  logic sample_valid, frame_error, valid_u, error_u;

  word_t  words[$];
  frame_t exp_q[$];
  int n_checks = 0, n_pass = 0, n_expected = 0, n_strobes = 0;
  event lat_ev;

  i2s_rx #(.DATA_WIDTH(DW), .UNSIGNED_OUT(1'b0)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .lrclk(lrclk), .sdata(sdata),
    .left_chan(left_chan), .right_chan(right_chan),
    .sample_valid(sample_valid), .frame_error(frame_error)
  );

  i2s_rx #(.DATA_WIDTH(DW), .UNSIGNED_OUT(1'b1)) dut_u (
    .clk(clk), .reset(reset), .sclk(sclk), .lrclk(lrclk), .sdata(sdata),
    .left_chan(left_u), .right_chan(right_u),
    .sample_valid(valid_u), .frame_error(error_u)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Bit i (0 = MSB) of an n-bit word; bits above the 64-bit value field are zero.
  function automatic bit word_bit(input logic [63:0] v, input int n, input int i);
    int pos = n - 1 - i;
    return (pos < 64) ? v[pos] : 1'b0;
  endfunction

  // Received word: first DW bits sent, zero-padded when the word is short.
  function automatic logic [DW-1:0] model_word(input logic [63:0] v, input int n);
    logic [DW-1:0] w = '0;
    for (int i = 0; i < DW; i++) if (i < n) w[DW-1-i] = word_bit(v, n, i);
    return w;
  endfunction

  task automatic add_word(input bit ch, input int len, input logic [63:0] val,
                          input int half, input int rst_at);
    word_t w;
    w.ch = ch; w.len = len; w.val = val; w.half = half; w.rst_at = rst_at;
    words.push_back(w);
  endtask

  task automatic add_frame(input logic [63:0] l, input logic [63:0] r, input int len,
                           input int half, input int rst_at);
    add_word(1'b0, len, l, half, rst_at);
    add_word(1'b1, len, r, half, -1);
  endtask

  // Drives the stream and predicts strobes: after a reset the first rise only
  // primes, a word counts once a word boundary has been seen before it starts,
  // and a frame strobes when its left and right words both count.
  task automatic play();
    bit primed_b = 1'b0, aligned = 1'b0, left_good = 1'b0, ok;
    logic [DW-1:0] left_exp = '0;
    bit left_err = 1'b0;
    word_t w;
    frame_t f;
    foreach (words[k]) begin
      w  = words[k];
      ok = aligned;
      for (int s = 0; s < w.len; s++) begin
        sclk  = 1'b0;
        lrclk = (s == w.len - 1) ? ~w.ch : w.ch;
        sdata = word_bit(w.val, w.len, s);
        if (s == w.rst_at) begin
          @(posedge clk); #2 reset = 1'b1;
          @(posedge clk); #2 reset = 1'b0;
          check("rst_left", left_chan, 0);
          check("rst_right", right_chan, 0);
          check("rst_valid", sample_valid, 0);
          check("rst_error", frame_error, 0);
          primed_b = 1'b0; aligned = 1'b0; left_good = 1'b0; ok = 1'b0;
        end
        repeat (w.half) @(posedge clk);
        #2 sclk = 1'b1;
        if (!primed_b) primed_b = 1'b1;
        else if (s == w.len - 1) begin
          if (!w.ch) begin
            left_good = ok;
            left_exp  = model_word(w.val, w.len);
            left_err  = (w.len < DW);
          end else begin
            if (ok && left_good) begin
              f.l = left_exp;
              f.r = model_word(w.val, w.len);
              f.e = left_err | (w.len < DW);
              exp_q.push_back(f);
              n_expected++;
              -> lat_ev;
            end
            left_good = 1'b0;
          end
          aligned = 1'b1;
        end
        repeat (w.half) @(posedge clk);
        #2;
      end
    end
  endtask

  // Strobe scoreboard, sampled 1 time unit after each clk edge.
  initial begin
    frame_t f;
    logic prev_valid = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (sample_valid) begin
        n_strobes++;
        check("no_back_to_back", prev_valid, 0);
        check("u_valid_coincident", valid_u, 1);
        check("strobe_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          f = exp_q.pop_front();
          check("left_chan", left_chan, f.l);
          check("right_chan", right_chan, f.r);
          check("frame_error", frame_error, f.e);
          check("left_u", left_u, {~f.l[DW-1], f.l[DW-2:0]});
          check("right_u", right_u, {~f.r[DW-1], f.r[DW-2:0]});
          check("error_u", error_u, f.e);
        end
      end else if (frame_error) begin
        check("error_without_valid", frame_error, 0);
      end
      prev_valid = sample_valid;
    end
  end

  // Strobe lands on the 3rd clk edge after the pin sclk rise of the right boundary bit.
  initial begin
    forever begin
      @(lat_ev);
      repeat (2) @(posedge clk);
      #1 check("latency_early", sample_valid, 0);
      @(posedge clk);
      #1 check("latency", sample_valid, 1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lens[8] = '{8, 12, 15, 16, 17, 24, 32, 70};
    reset = 1'b1; sclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b0;
    check("reset_left", left_chan, 0);
    check("reset_right", right_chan, 0);
    check("reset_valid", sample_valid, 0);
    check("reset_error", frame_error, 0);
    check("reset_left_u", left_u, 0);

    add_word(1'b1, 7, 64'h55, 6, -1);                  // stream starts mid-right-word
    repeat (3) add_frame(64'h1234, 64'hABCD, 16, 6, -1);
    add_frame(64'h80FF00, 64'h7F00FF, 24, 6, -1);
    add_frame(64'hABC, 64'h123, 12, 6, -1);
    add_frame(64'h0000, 64'hFFFF, 16, 6, -1);
    add_frame(64'hC000, 64'hC000, 16, 6, -1);
    add_frame(64'hC000, 64'hC000, 16, 6, 6);            // reset mid-left-word
    add_frame(64'hC000, 64'hC000, 16, 6, -1);
    for (int i = 0; i < 24; i++) begin
      int h = $urandom_range(2, 4);
      add_word(1'b0, lens[$urandom_range(0, 7)], {$urandom, $urandom}, h, -1);
      add_word(1'b1, lens[$urandom_range(0, 7)], {$urandom, $urandom}, h, -1);
    end
    add_word(1'b0, 4, 64'h9, 4, -1);

    play();
    repeat (20) @(posedge clk);
    #1;
    check("pending_frames", exp_q.size(), 0);
    check("strobe_count", n_strobes, n_expected);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- I2S receiver (deserializer), the receive end of the I2S link that the core's `i2s` transmitter drives.
- Oversamples external sclk/lrclk/sdata in the system clock domain and recovers left/right PCM words.
- Presents each frame as a parallel sample pair with a one-cycle valid strobe.
- Feeds the audio-in path (USE_AUDIO_IN builds) and loopback testing of the `i2s` transmitter.

Parameters:
- DATA_WIDTH, 16, bits captured per channel word; legal range 8..32.
- UNSIGNED_OUT, 0:
  - 0: output two's complement as received.
  - 1: output MSB inverted (offset binary, the format of the core's 16-bit `audio` bus as fed to `dac`).

Ports:
- clk, input, 1, system clock; must be at least 4x sclk, and sclk high and low phases must each last at least 2 clk periods.
- reset, input, 1, synchronous, active-high.
- sclk, input, 1, I2S bit clock; asynchronous to clk.
- lrclk, input, 1, I2S word select; 0 = left, 1 = right.
- sdata, input, 1, I2S serial data, MSB first.
- left_chan, output, DATA_WIDTH, last complete left word.
- right_chan, output, DATA_WIDTH, last complete right word.
- sample_valid, output, 1, one-clk pulse when left_chan/right_chan update.
- frame_error, output, 1, one-clk pulse coincident with sample_valid when either word of the frame was short.

Behaviour:
- Reset values:
  - left_chan = 0, right_chan = 0, sample_valid = 0, frame_error = 0.
  - All synchronizer, shift, counter and flag registers cleared; primed = 0; started = 0; left_ok = 0.
  - Reset asserted mid-frame discards the partial frame; no strobe is produced for it.
- Input sync:
  - sclk, lrclk and sdata each pass through an identical 2-FF synchronizer, plus a third sclk stage for edge detection.
  - rise = sclk_s1 & ~sclk_s2. All processing below happens only on clk cycles where rise = 1.
- Priming: the first rise after reset only loads lrclk_prev from the synchronized lrclk and sets primed. This prevents a false boundary from reset values.
- Per rise, when primed:
  - Word boundary is detected when lrclk_sync != lrclk_prev. I2S places the previous word's LSB in this slot.
  - Capture of the sampled bit:
    - If bitcnt < DATA_WIDTH, the sampled sdata is stored at position DATA_WIDTH-1-bitcnt of the word register.
    - Bits beyond DATA_WIDTH are ignored (truncation).
    - bitcnt (6 bits) increments and saturates at 63.
  - At a boundary, the word just completed, including this bit, belongs to channel lrclk_prev.
    - The word is short if its total bit count is < DATA_WIDTH. Missing LSBs are 0, i.e. the word is left-justified and zero-padded.
  - Then the word register is cleared, bitcnt = 0, lrclk_prev = lrclk_sync, and started = 1.
  - The next rise samples the MSB of the new word.
- Word completion (boundary, started already 1 before this boundary):
  - prev = 0 (left): left_hold = word, left_short = short, left_ok = 1.
  - prev = 1 (right) with left_ok = 1:
    - left_chan = left_hold and right_chan = word (MSB inverted if UNSIGNED_OUT).
    - sample_valid = 1 and frame_error = left_short | short, both for exactly one clk.
    - left_ok is then cleared.
  - prev = 1 with left_ok = 0: the word is discarded and no strobe is issued. This covers the partial first frame after reset or lock.
- Latency: sample_valid is high on the 3rd clk edge after the sclk rising edge that carries the right word's boundary bit is present at the pin.
- Outputs hold their values between strobes. sample_valid is never high on two consecutive cycles.
- A word longer than 63 bits still completes normally: the counter saturates and no wrap occurs.
- Simultaneous events: a boundary completes the old word and starts the new word within the same rise-cycle; no bit is lost or duplicated.

Test Plan:
- Nominal frame:
  - Stimulus: reset; then clk 36 MHz, sclk 36/12 MHz, 32 bits/frame, DATA_WIDTH=16; send L=16'h1234, R=16'hABCD for 3 frames.
  - Expected: the first complete frame yields left_chan=1234, right_chan=ABCD, sample_valid once per frame, frame_error=0.
  - Expected: the pulse lands 3 clk edges after the pin sclk rise of the R→L boundary bit.
- Partial first frame: start the stream mid-right-word after reset → no strobe until a full L+R pair has been received, then correct values.
- Long words: 24-bit words L=24'h80FF00, R=24'h7F00FF, DATA_WIDTH=16 → left_chan=80FF, right_chan=7F00, frame_error=0.
- Short word: 12-bit words L=12'hABC, R=12'h123 → left_chan=ABC0, right_chan=1230, frame_error=1 coincident with sample_valid.
- UNSIGNED_OUT=1: L=16'h0000, R=16'hFFFF → left_chan=8000, right_chan=7FFF.
- Loopback and reset mid-frame:
  - Stimulus: loop back the core `i2s` transmitter sending {~audio[15],audio[14:0]} with audio=16'h4000, and assert reset for 1 clk mid-left-word.
  - Expected: all outputs 0 the cycle after reset; the next full frame outputs left_chan=right_chan=16'hC000 (UNSIGNED_OUT=0).
